// File: rtl/game_input_conditioner.sv
// Game input conditioner: synchronizes and debounces four push-buttons,
// generates the game tick, move levels, rate-limited shots and start pulses.
module game_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 416667,
    parameter int SHOOT_COOLDOWN  = 12
) (
    input  logic i_Clock,
    input  logic i_Reset,
    input  logic i_BtnLeft,
    input  logic i_BtnRight,
    input  logic i_BtnShoot,
    input  logic i_BtnStart,
    output logic o_Tick,
    output logic o_PlayerMoveLeft,
    output logic o_PlayerMoveRight,
    output logic o_PlayerBulletShoot,
    output logic o_GameStartStop
);

    localparam int DW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (SHOOT_COOLDOWN > 0) ? $clog2(SHOOT_COOLDOWN + 1) : 1;

    localparam int B_LEFT  = 0;
    localparam int B_RIGHT = 1;
    localparam int B_SHOOT = 2;
    localparam int B_START = 3;

    logic [3:0]    w_Raw;
    logic [3:0]    w_Press;
    logic          w_ShotOk;

    logic [3:0]    r_Sync1;
    logic [3:0]    r_Sync2;
    logic [3:0]    r_Deb;
    logic [3:0]    r_Prev;
    logic [DW-1:0] r_DebCnt [4];
    logic [TW-1:0] r_TickCnt;
    logic [CW-1:0] r_Cool;

    assign w_Raw    = {i_BtnStart, i_BtnShoot, i_BtnRight, i_BtnLeft};
    // Debounced level went released (1) -> pressed (0) at the last edge.
    assign w_Press  = r_Prev & ~r_Deb;
    assign w_ShotOk = w_Press[B_SHOOT] && (r_Cool == '0);

    // Two-flop synchronizers and per-button stable-count debouncers.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_Sync1 <= 4'hF;
            r_Sync2 <= 4'hF;
            r_Deb   <= 4'hF;
            for (int i = 0; i < 4; i++) begin
                r_DebCnt[i] <= '0;
            end
        end else begin
            r_Sync1 <= w_Raw;
            r_Sync2 <= r_Sync1;
            for (int i = 0; i < 4; i++) begin
                if (r_Sync2[i] == r_Deb[i]) begin
                    r_DebCnt[i] <= '0;
                end else if (r_DebCnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    r_Deb[i]    <= ~r_Deb[i];
                    r_DebCnt[i] <= '0;
                end else begin
                    r_DebCnt[i] <= r_DebCnt[i] + DW'(1);
                end
            end
        end
    end

    // Free-running tick divider; the pulse is registered off the wrap value.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_TickCnt <= '0;
            o_Tick    <= 1'b0;
        end else begin
            o_Tick <= (r_TickCnt == TW'(TICK_DIV - 1));
            if (r_TickCnt == TW'(TICK_DIV - 1)) begin
                r_TickCnt <= '0;
            end else begin
                r_TickCnt <= r_TickCnt + TW'(1);
            end
        end
    end

    // Shot cooldown: a load on an accepted shot wins over the tick decrement.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_Cool <= '0;
        end else if (w_ShotOk) begin
            r_Cool <= CW'(SHOOT_COOLDOWN);
        end else if (o_Tick && (r_Cool != '0)) begin
            r_Cool <= r_Cool - CW'(1);
        end
    end

    // Registered outputs and the previous-state copy for edge detection.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            r_Prev              <= 4'hF;
            o_PlayerMoveLeft    <= 1'b0;
            o_PlayerMoveRight   <= 1'b0;
            o_PlayerBulletShoot <= 1'b0;
            o_GameStartStop     <= 1'b0;
        end else begin
            r_Prev              <= r_Deb;
            o_PlayerMoveLeft    <= ~r_Deb[B_LEFT] & r_Deb[B_RIGHT];
            o_PlayerMoveRight   <= ~r_Deb[B_RIGHT] & r_Deb[B_LEFT];
            o_PlayerBulletShoot <= w_ShotOk;
            o_GameStartStop     <= w_Press[B_START];
        end
    end

endmodule

// File: tb/tb_game_input_conditioner.sv
// Bench for game_input_conditioner: directed scenarios plus random button
// activity, compared every clock against a window-based behavioural model.
module tb_game_input_conditioner;

    localparam int D  = 4;
    localparam int TD = 5;
    localparam int CD = 3;

    logic i_Clock = 1'b0;
    logic i_Reset = 1'b1;
    logic i_BtnLeft = 1'b1;
    logic i_BtnRight = 1'b1;
    logic i_BtnShoot = 1'b1;
    logic i_BtnStart = 1'b1;
    logic o_Tick;
    logic o_PlayerMoveLeft;
    logic o_PlayerMoveRight;
    logic o_PlayerBulletShoot;
    logic o_GameStartStop;

    game_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV(TD),
        .SHOOT_COOLDOWN(CD)
    ) dut (
        .i_Clock(i_Clock),
        .i_Reset(i_Reset),
        .i_BtnLeft(i_BtnLeft),
        .i_BtnRight(i_BtnRight),
        .i_BtnShoot(i_BtnShoot),
        .i_BtnStart(i_BtnStart),
        .o_Tick(o_Tick),
        .o_PlayerMoveLeft(o_PlayerMoveLeft),
        .o_PlayerMoveRight(o_PlayerMoveRight),
        .o_PlayerBulletShoot(o_PlayerBulletShoot),
        .o_GameStartStop(o_GameStartStop)
    );

    always #5 i_Clock = ~i_Clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: raw samples per button (oldest first), debounced/previous levels,
    // tick phase, remaining cooldown ticks and expected outputs.
    bit hq [4][$];
    bit m_deb [4];
    bit m_prev [4];
    int m_tcnt;
    int m_cd;
    bit m_tick, m_L, m_R, m_S, m_St;

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] outs();
        return {o_Tick, o_PlayerMoveLeft, o_PlayerMoveRight,
                o_PlayerBulletShoot, o_GameStartStop};
    endfunction

    task automatic m_reset();
        for (int b = 0; b < 4; b++) begin
            hq[b].delete();
            repeat (D + 2) hq[b].push_back(1'b1);
            m_deb[b]  = 1'b1;
            m_prev[b] = 1'b1;
        end
        m_tcnt = 0;
        m_cd   = 0;
        m_tick = 0; m_L = 0; m_R = 0; m_S = 0; m_St = 0;
    endtask

    // One rising edge: a button's level flips once the D samples that have
    // passed the 2-stage synchronizer all show the opposite level.
    task automatic m_edge(input bit [3:0] raw);
        bit nd [4];
        bit ev [4];
        bit flip;
        for (int b = 0; b < 4; b++) begin
            void'(hq[b].pop_front());
            hq[b].push_back(raw[b]);
            flip = 1'b1;
            for (int k = 0; k < D; k++) begin
                if (hq[b][k] == m_deb[b]) flip = 1'b0;
            end
            nd[b] = flip ? !m_deb[b] : m_deb[b];
            ev[b] = !m_deb[b] && m_prev[b];
        end
        m_L  = !m_deb[0] && m_deb[1];
        m_R  = !m_deb[1] && m_deb[0];
        m_St = ev[3];
        if (ev[2] && m_cd == 0) begin
            m_S  = 1'b1;
            m_cd = CD;
        end else begin
            m_S = 1'b0;
            if (m_tick && m_cd > 0) m_cd--;
        end
        m_tick = (m_tcnt == TD - 1);
        m_tcnt = (m_tcnt + 1) % TD;
        m_prev = m_deb;
        m_deb  = nd;
    endtask

    task automatic step();
        @(posedge i_Clock);
        m_edge({i_BtnStart, i_BtnShoot, i_BtnRight, i_BtnLeft});
        #1;
        chk("model", outs(), {m_tick, m_L, m_R, m_S, m_St});
    endtask

    task automatic do_reset();
        i_Reset = 1'b0;
        #1;
        chk("reset_outs", outs(), 5'b0);
        @(posedge i_Clock);
        @(posedge i_Clock);
        #1;
        chk("reset_hold", outs(), 5'b0);
        i_Reset = 1'b1;
        m_reset();
    endtask

    task automatic idle(input int n);
        i_BtnLeft = 1; i_BtnRight = 1; i_BtnShoot = 1; i_BtnStart = 1;
        repeat (n) step();
    endtask

    int hold [4];
    bit [3:0] rv;

    initial begin
        m_reset();
        #2;
        do_reset();

        // Idle: tick on edges 5, 10, 15 only.
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("tick_idle", {4'b0, o_Tick}, 5'(k % 5 == 0));
        end

        // Start glitch of 3 clocks: no pulse.
        i_BtnStart = 0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("start_glitch", {4'b0, o_GameStartStop}, 5'b0);
        end
        i_BtnStart = 1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("start_glitch", {4'b0, o_GameStartStop}, 5'b0);
        end

        // Start held 20 clocks: single pulse at edge 7.
        i_BtnStart = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("start_press", {4'b0, o_GameStartStop}, 5'(k == 7));
        end
        idle(10);

        // Left and right together, then release right.
        i_BtnLeft = 0; i_BtnRight = 0;
        repeat (10) step();
        chk("both_held", {3'b0, o_PlayerMoveLeft, o_PlayerMoveRight}, 5'b0);
        i_BtnRight = 1;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("left_after_r", {3'b0, o_PlayerMoveLeft, o_PlayerMoveRight},
                {3'b0, 1'(k >= 7), 1'b0});
        end
        idle(10);

        // Shot on a tick clock; re-press while cooldown is 1 is dropped.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            i_BtnShoot = !((k >= 5 && k <= 14) || k >= 20);
            step();
            chk("cool_drop", {4'b0, o_PlayerBulletShoot}, 5'(k == 11));
        end
        idle(5);

        // Same, but re-press lands once cooldown has reached 0.
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            i_BtnShoot = !((k >= 5 && k <= 14) || k >= 21);
            step();
            chk("cool_accept", {4'b0, o_PlayerBulletShoot}, 5'(k == 11 || k == 27));
        end
        idle(10);

        // Periodic shoot presses every 8 clocks.
        for (int k = 0; k < 64; k++) begin
            i_BtnShoot = (k % 8) >= 4 ? 1'b0 : 1'b1;
            step();
        end
        idle(10);

        // Reset during a start debounce count; held button pulses afresh.
        i_BtnStart = 0;
        repeat (4) step();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("start_rst", {4'b0, o_GameStartStop}, 5'(k == 7));
        end
        idle(10);

        // Reset during cooldown; held shoot is accepted afresh.
        i_BtnShoot = 0;
        repeat (9) step();
        do_reset();
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("shoot_rst", {4'b0, o_PlayerBulletShoot}, 5'(k == 7));
        end
        idle(10);

        // Random button activity with held levels of varying length.
        for (int b = 0; b < 4; b++) hold[b] = 0;
        rv = 4'hF;
        for (int c = 0; c < 600; c++) begin
            for (int b = 0; b < 4; b++) begin
                if (hold[b] == 0) begin
                    rv[b]   = 1'($urandom_range(0, 1));
                    hold[b] = $urandom_range(1, 10);
                end
                hold[b]--;
            end
            {i_BtnStart, i_BtnShoot, i_BtnRight, i_BtnLeft} = rv;
            if (c == 300) do_reset();
            step();
        end
        idle(12);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/game_input_conditioner.md
GAME_INPUT_CONDITIONER -- requirements
Module: game_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000; consecutive stable clocks required to accept a button change (10 ms at 25 MHz).
REQ-002 Parameter TICK_DIV, default 416667; clocks per game tick (60 Hz at 25 MHz).
REQ-003 Parameter SHOOT_COOLDOWN, default 12; minimum ticks between accepted shots.
REQ-004 i_Clock  in  1  system clock.
REQ-005 i_Reset  in  1  asynchronous, active-low reset.
REQ-006 i_BtnLeft, i_BtnRight, i_BtnShoot, i_BtnStart  in  1 each  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-007 o_Tick  out  1  one-clock game tick pulse.
REQ-008 o_PlayerMoveLeft, o_PlayerMoveRight  out  1 each  debounced move levels, active-high.
REQ-009 o_PlayerBulletShoot  out  1  one-clock accepted-shot pulse, active-high.
REQ-010 o_GameStartStop  out  1  one-clock start/stop press pulse, active-high.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-012 Each button SHALL hold a debounced state register and a counter of width $clog2(DEBOUNCE_CYCLES+1); counter clears whenever the synchronized value equals the debounced state.
REQ-013 When synchronized value differs from debounced state for DEBOUNCE_CYCLES consecutive clocks, the debounced state SHALL toggle and the counter clear in the same edge.
REQ-014 A glitch shorter than DEBOUNCE_CYCLES clocks SHALL leave the debounced state and all outputs unchanged.
REQ-015 Press events (debounced released->pressed) SHALL be detected against a registered previous debounced state; release events SHALL produce no pulse.
REQ-016 Latency: a clean raw press held steady SHALL produce its output change/pulse at exactly the (DEBOUNCE_CYCLES+3)-th rising edge after the edge that first samples it.
REQ-017 Tick counter SHALL count 0..TICK_DIV-1 and wrap to 0; o_Tick SHALL be 1 for exactly the clock in which the counter equals TICK_DIV-1; free-running, independent of buttons.
REQ-018 o_PlayerMoveLeft/Right SHALL be registered copies of the debounced pressed levels; when both are pressed both outputs SHALL be 0.
REQ-019 Shoot cooldown counter, width $clog2(SHOOT_COOLDOWN+1): on a shoot press event with cooldown = 0, o_PlayerBulletShoot SHALL pulse one clock and cooldown SHALL load SHOOT_COOLDOWN.
REQ-020 Cooldown SHALL decrement by 1 on each o_Tick while nonzero and saturate at 0.
REQ-021 A shoot press event while cooldown != 0 SHALL be dropped (not queued); holding the button SHALL NOT auto-repeat.
REQ-022 Shot accepted in the same clock as o_Tick: load of SHOOT_COOLDOWN SHALL take priority over decrement.
REQ-023 o_GameStartStop SHALL pulse one clock per start press event, no rate limit.
REQ-024 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-025 While i_Reset = 0: all outputs 0, tick counter 0, cooldown 0, all debounce counters 0, synchronizer flops and debounced/previous states = 1 (released).
REQ-026 Reset asserted mid-operation SHALL abort immediately; pending debounce counts and cooldown are discarded.
REQ-027 A button held low through reset release SHALL be treated as a new press and generate its pulse/level DEBOUNCE_CYCLES+3 edges after release.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5, SHOOT_COOLDOWN=3)
REQ-028 Reset released, no buttons -> o_Tick high on edges 5, 10, 15 after release, all other outputs 0.
REQ-029 i_BtnStart low for 3 clocks then high -> no o_GameStartStop pulse; low held 20 clocks -> exactly one 1-clock pulse at edge 7 after first sampled low.
REQ-030 Shoot pressed/released cleanly every 8 clocks -> pulses only when cooldown = 0; second press within 3 ticks of an accepted shot produces no pulse.
REQ-031 Shot accepted on a tick clock -> cooldown reads 3, then 2, 1, 0 on the next three ticks; next press accepted only after 0.
REQ-032 Left and right held together -> both move outputs 0; release right -> o_PlayerMoveLeft = 1 seven edges later.
REQ-033 Reset pulsed during a debounce count and during cooldown -> all outputs 0 immediately, cooldown 0, held button yields fresh pulse 7 edges after reset release.
